voice_alloc: RTL
================

VOICE_ALLOC -- requirements
Module: voice_alloc

Interface
REQ-001 SHALL have parameter NUM_VOICES, default 4, giving the number of voice channels, each channel being one pitch/vibrato generator.
REQ-002 SHALL have parameter AGE_W, default 4, giving the width of each per-voice saturating age counter.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset_n, input, 1 bit: reset, synchronous and active-low.
REQ-005 SHALL have port en, input, 1 bit: core enable; when 0, the FSM and all registers hold and ev_ready=0.
REQ-006 SHALL have port panic, input, 1 bit: all-notes-off request.
REQ-007 SHALL have port ev_valid, input, 1 bit: MIDI event present.
REQ-008 SHALL have port ev_ready, output, 1 bit: block can accept an event.
REQ-009 SHALL have port ev_on, input, 1 bit: 1 = note-on, 0 = note-off.
REQ-010 SHALL have port ev_note, input, 7 bits: MIDI note number.
REQ-011 SHALL have port ev_vel, input, 7 bits: velocity; a note-on with ev_vel=0 is treated as note-off.
REQ-012 SHALL have port voice_on, output, NUM_VOICES bits: per-voice gate (note_on of each channel).
REQ-013 SHALL have port voice_note, output, 7*NUM_VOICES bits: per-voice note, voice i at bits [7i+6:7i].
REQ-014 SHALL have port voice_vel, output, 7*NUM_VOICES bits: per-voice velocity, same packing as voice_note.
REQ-015 SHALL have port voice_repeat, output, NUM_VOICES bits: one-cycle retrigger pulse per voice (note_repeat of each channel).

Function
REQ-016 SHALL implement FSM states IDLE, SEARCH, COMMIT; ev_ready=1 only in IDLE with en=1 and panic=0.
REQ-017 SHALL accept an event on a rising edge with ev_valid=1 and ev_ready=1; it SHALL latch ev_on/ev_note/ev_vel and move to SEARCH.
REQ-018 SHALL, in SEARCH, examine one voice per cycle, index 0 upward, for exactly NUM_VOICES cycles, then move to COMMIT.
REQ-019 SHALL record during SEARCH: the first active voice whose note matches; the lowest-index inactive voice; and the oldest active voice (max age, ties to lowest index).
REQ-020 SHALL, in COMMIT, update outputs on that edge and return to IDLE; outputs change NUM_VOICES+1 edges after the acceptance edge; throughput is one event per NUM_VOICES+2 cycles.
REQ-021 Note-on SHALL select, by priority: (a) the matching active voice, which gets voice_vel updated, age=0 and voice_repeat pulsed for one cycle; (b) else the lowest free voice, which gets voice_on=1 and note/vel loaded; (c) else the oldest voice is stolen: note/vel loaded, voice_on stays 1, no repeat pulse.
REQ-022 On a committed note-on, SHALL increment the age of every other active voice, saturating at 2^AGE_W-1; the selected voice's age SHALL become 0.
REQ-023 Note-off SHALL clear voice_on of the matching active voice and leave its voice_note/voice_vel unchanged; with no match it SHALL change nothing.
REQ-024 voice_repeat SHALL be 0 in every cycle other than the one following a COMMIT that retriggers a voice.
REQ-025 panic=1 with en=1 SHALL, on that edge, clear all voice_on and ages and discard any in-flight event, returning to IDLE; it takes priority over every other action.
REQ-026 en=0 mid-SEARCH SHALL freeze the scan index, and the scan SHALL resume unchanged when en returns to 1.

Reset
REQ-027 reset_n=0 on a rising edge SHALL force IDLE, voice_on=0, voice_note=0, voice_vel=0, voice_repeat=0, all ages=0, and the scan index to 0, regardless of en or panic.
REQ-028 Reset asserted mid-SEARCH or mid-COMMIT SHALL discard the event, and no output update from that event SHALL occur.
REQ-029 ev_ready SHALL be 0 while reset_n=0, and SHALL be 1 in the first cycle after release when en=1.

Verification
REQ-030 Reset, en=1, then on(60, vel 100) -> voice_on=0001 and voice0 note=60, vel=100 exactly 5 edges after acceptance; ev_ready low for those cycles.
REQ-031 on 60, 62, 64, 65, then on 67 -> voices 0-3 hold 60/62/64/65; 67 steals voice0 (oldest, age 3); voice_repeat stays 0.
REQ-032 on 60, then on 60 vel 20 -> voice0 vel=20, voice_repeat=0001 for exactly one cycle, voice_on unchanged, no second voice used.
REQ-033 on 60 and 62, off 60, on 70 -> voice0 gate 0 after the off, then voice0 reused for 70 (lowest free); off 99 -> no output change.
REQ-034 Hold ev_valid=1 with a queued on(72) and pulse panic during SEARCH -> voice_on=0000 next cycle, event dropped, ev_ready=1 afterwards.
REQ-035 en=0 for 10 cycles mid-SEARCH, then en=1 -> commit occurs 10 cycles late with a correct result; reset_n=0 mid-SEARCH -> all outputs 0, no commit.

Source files
------------

// File: rtl/voice_alloc.sv
// MIDI voice allocator: each accepted event scans one voice per cycle, then commits in a single edge.
// Note-on priority is retrigger of a matching voice, then the lowest free voice, then stealing the oldest.
module voice_alloc #(
  parameter int NUM_VOICES = 4,
  parameter int AGE_W      = 4
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    en,
  input  logic                    panic,
  input  logic                    ev_valid,
  output logic                    ev_ready,
  input  logic                    ev_on,
  input  logic [6:0]              ev_note,
  input  logic [6:0]              ev_vel,
  output logic [NUM_VOICES-1:0]   voice_on,
  output logic [7*NUM_VOICES-1:0] voice_note,
  output logic [7*NUM_VOICES-1:0] voice_vel,
  output logic [NUM_VOICES-1:0]   voice_repeat
);
  localparam int IDX_W = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] SEARCH = 2'd1;
  localparam logic [1:0] COMMIT = 2'd2;
  localparam logic [IDX_W-1:0] LAST = IDX_W'(NUM_VOICES - 1);

  logic [1:0]            state;
  logic [IDX_W-1:0]      idx;
  logic                  ev_on_q;
  logic [6:0]            note_q;
  logic [6:0]            vel_q;
  logic                  match_hit;
  logic                  free_hit;
  logic                  old_hit;
  logic [IDX_W-1:0]      match_idx;
  logic [IDX_W-1:0]      free_idx;
  logic [IDX_W-1:0]      old_idx;
  logic [AGE_W-1:0]      old_age;
  logic [6:0]            note_r [NUM_VOICES];
  logic [6:0]            vel_r  [NUM_VOICES];
  logic [AGE_W-1:0]      age_r  [NUM_VOICES];
  logic [NUM_VOICES-1:0] on_r;
  logic [NUM_VOICES-1:0] rep_r;
  logic                  note_on_ev;
  logic [IDX_W-1:0]      sel;

  assign ev_ready   = reset_n && en && !panic && (state == IDLE);
  assign note_on_ev = ev_on_q && (vel_q != 7'd0);
  assign voice_on     = on_r;
  assign voice_repeat = rep_r;

  // When no voice is free every voice is active, so old_idx is always valid here.
  always_comb begin
    sel = old_idx;
    if (match_hit)
      sel = match_idx;
    else if (free_hit)
      sel = free_idx;
  end

  always_comb begin
    voice_note = '0;
    voice_vel  = '0;
    for (int i = 0; i < NUM_VOICES; i++) begin
      voice_note[7*i +: 7] = note_r[i];
      voice_vel[7*i +: 7]  = vel_r[i];
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state     <= IDLE;
      idx       <= '0;
      ev_on_q   <= 1'b0;
      note_q    <= '0;
      vel_q     <= '0;
      match_hit <= 1'b0;
      free_hit  <= 1'b0;
      old_hit   <= 1'b0;
      match_idx <= '0;
      free_idx  <= '0;
      old_idx   <= '0;
      old_age   <= '0;
      on_r      <= '0;
      rep_r     <= '0;
      for (int i = 0; i < NUM_VOICES; i++) begin
        note_r[i] <= '0;
        vel_r[i]  <= '0;
        age_r[i]  <= '0;
      end
    end else begin
      rep_r <= '0;
      if (en) begin
        if (panic) begin
          state <= IDLE;
          idx   <= '0;
          on_r  <= '0;
          for (int i = 0; i < NUM_VOICES; i++)
            age_r[i] <= '0;
        end else begin
          case (state)
            IDLE: begin
              if (ev_valid) begin
                ev_on_q   <= ev_on;
                note_q    <= ev_note;
                vel_q     <= ev_vel;
                match_hit <= 1'b0;
                free_hit  <= 1'b0;
                old_hit   <= 1'b0;
                idx       <= '0;
                state     <= SEARCH;
              end
            end
            SEARCH: begin
              if (on_r[idx] && (note_r[idx] == note_q) && !match_hit) begin
                match_hit <= 1'b1;
                match_idx <= idx;
              end
              if (!on_r[idx] && !free_hit) begin
                free_hit <= 1'b1;
                free_idx <= idx;
              end
              // Strict '>' keeps the lowest index on equal ages.
              if (on_r[idx] && (!old_hit || (age_r[idx] > old_age))) begin
                old_hit <= 1'b1;
                old_idx <= idx;
                old_age <= age_r[idx];
              end
              if (idx == LAST) begin
                idx   <= '0;
                state <= COMMIT;
              end else begin
                idx <= idx + 1'b1;
              end
            end
            COMMIT: begin
              state <= IDLE;
              if (note_on_ev) begin
                for (int i = 0; i < NUM_VOICES; i++) begin
                  if (IDX_W'(i) == sel)
                    age_r[i] <= '0;
                  else if (on_r[i] && (age_r[i] != '1))
                    age_r[i] <= age_r[i] + 1'b1;
                end
                vel_r[sel] <= vel_q;
                if (match_hit) begin
                  rep_r[sel] <= 1'b1;
                end else begin
                  on_r[sel]   <= 1'b1;
                  note_r[sel] <= note_q;
                end
              end else if (match_hit) begin
                on_r[match_idx] <= 1'b0;
              end
            end
            default: state <= IDLE;
          endcase
        end
      end
    end
  end
endmodule
